e_mdu: RTL
==========

# e_mdu

Multiply/divide unit for the E stage of the five-stage pipeline. It owns the architectural HI and LO registers and executes mult, multu, div, divu, mthi and mtlo. Its outputs feed the E-stage result mux for mfhi/mflo, and that value is latched into the E/M pipeline register. It exposes Start and Busy so that D-stage hazard logic can stall any HI/LO-related instruction while an operation is in flight.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- MDOp  in  3  op of the instruction in E: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none)
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- Start  out  1  combinational; 1 when MDOp ∈ {001..100} and Busy=0
- Busy  out  1  registered; 1 while an operation is in flight
- HiOut  out  32  committed HI register
- LoOut  out  32  committed LO register

## Operation
- Internal state:
  - HI and LO: committed registers, driven on HiOut/LoOut.
  - TmpHi and TmpLo: pending result.
  - Cnt: down-counter, 4 bits minimum, sized to max(MULT_CYCLES, DIV_CYCLES).
  - Busy flag.
- States:
  - IDLE (Busy=0).
  - RUN (Busy=1, Cnt counts down).
- IDLE, MDOp = mult/multu/div/divu:
  - The result is computed combinationally from A and B in this cycle and captured into TmpHi/TmpLo at the edge.
  - At the same edge, Cnt is loaded with MULT_CYCLES or DIV_CYCLES, Busy goes to 1 and the state becomes RUN.
- IDLE, MDOp = mthi/mtlo: HI←A (or LO←A) at the edge. Busy stays 0 and no latency is added.
- RUN, each edge:
  - While Cnt>1: Cnt decrements.
  - When Cnt==1: HI←TmpHi, LO←TmpLo, Busy←0, Cnt←0, state returns to IDLE.
- Ops presented while Busy=1 are ignored. Upstream guarantees they never occur, because D stalls on (Start|Busy) with an HI/LO instruction in D.
- HI and LO change only at commit or on mthi/mtlo. HiOut/LoOut keep their old values during RUN.
- Arithmetic:
  - mult: {HI,LO} = signed(A)×signed(B), 64-bit.
  - multu: {HI,LO} = A×B unsigned, 64-bit.
  - div: LO = signed quotient truncated toward zero; HI = remainder carrying the sign of the dividend A.
  - divu: LO = A/B unsigned; HI = A%B unsigned.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Divide by zero (div/divu with B=0):
  - Busy still asserts for DIV_CYCLES.
  - At commit, HI and LO keep their prior values; TmpHi/TmpLo are loaded from the current HI/LO.

## Timing
- Reset: HI=0, LO=0, Busy=0, Cnt=0, TmpHi=TmpLo=0. Start follows MDOp combinationally (Busy=0).
- Reset asserted in RUN aborts the operation at that edge. No commit occurs and HI/LO become 0.
- Latency:
  - Start high in cycle t.
  - Busy=1 in cycles t+1 … t+N, where N is MULT_CYCLES or DIV_CYCLES.
  - New HI/LO are visible on HiOut/LoOut from cycle t+N+1, the same cycle in which Busy=0.
- mfhi/mflo issued in cycle t+N+1 reads the new value. No bypass of Tmp registers is provided.
- Back-to-back: a new op may start in cycle t+N+1 (Busy=0). The minimum repeat interval is N+1 cycles.
- mthi/mtlo in cycle t: the value is visible from cycle t+1.

## Test plan
- Reset, then mult A=0xFFFFFFFE (−2), B=3:
  - Start=1 for one cycle.
  - Busy=1 for exactly 5 cycles.
  - Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - HiOut/LoOut stay 0 while Busy.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF: after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=0xFFFFFFF9 (−7), B=2:
  - Busy=1 for 10 cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with the same operands: LO=0x7FFFFFFC, HI=0x00000001.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0, then div B=0:
  - HI=0x12345678 and LO=0x9ABCDEF0 one cycle after each write.
  - div B=0 holds Busy for 10 cycles and leaves HI/LO unchanged.
- Start div, hold MDOp=mult during Busy (ignored), and assert Reset in the 4th busy cycle:
  - Next cycle Busy=0, HI=LO=0.
  - A subsequent mult A=3, B=4 completes with LO=12, HI=0.

Source files
------------

// File: rtl/e_mdu_if.sv
// Operand, control and result bundle between the E stage and e_mdu.
// The pipeline side drives the operation. The unit returns its status and HI/LO.
interface e_mdu_if;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic        Busy;
  logic [31:0] HiOut;
  logic [31:0] LoOut;

  modport master (output MDOp, A, B, input Start, Busy, HiOut, LoOut);
  modport slave  (input MDOp, A, B, output Start, Busy, HiOut, LoOut);
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at issue, held in tmp registers, and committed after a fixed latency.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   Clk,
  input  logic   Reset,
  e_mdu_if.slave bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;

  logic               is_mul, is_div, sign_a, sign_b;
  logic [63:0]        prod;
  logic [31:0]        abs_a, abs_b, div_b, uq, ur, quot, rem;

  // Signed divide works on magnitudes, so 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    is_mul = (bus.MDOp == OP_MULT) || (bus.MDOp == OP_MULTU);
    is_div = (bus.MDOp == OP_DIV)  || (bus.MDOp == OP_DIVU);
    sign_a = (bus.MDOp == OP_MULT || bus.MDOp == OP_DIV) && bus.A[31];
    sign_b = (bus.MDOp == OP_MULT || bus.MDOp == OP_DIV) && bus.B[31];
    prod   = {{32{sign_a}}, bus.A} * {{32{sign_b}}, bus.B};
    abs_a  = sign_a ? -bus.A : bus.A;
    abs_b  = sign_b ? -bus.B : bus.B;
    div_b  = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uq     = abs_a / div_b;
    ur     = abs_a % div_b;
    quot   = (sign_a ^ sign_b) ? -uq : uq;
    rem    = sign_a ? -ur : ur;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    unique case (state_q)
      IDLE: begin
        if (is_mul) begin
          {tmp_hi_d, tmp_lo_d} = prod;
          cnt_d   = CNT_W'(MULT_CYCLES);
          state_d = RUN;
        end else if (is_div) begin
          tmp_hi_d = (bus.B == 32'd0) ? hi_q : rem;
          tmp_lo_d = (bus.B == 32'd0) ? lo_q : quot;
          cnt_d    = CNT_W'(DIV_CYCLES);
          state_d  = RUN;
        end else if (bus.MDOp == OP_MTHI) begin
          hi_d = bus.A;
        end else if (bus.MDOp == OP_MTLO) begin
          lo_d = bus.A;
        end
      end
      RUN: begin
        // Any op presented while running is ignored; the hazard logic keeps them out.
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          hi_d    = tmp_hi_q;
          lo_d    = tmp_lo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
    end
  end

  assign bus.Start = (is_mul || is_div) && (state_q == IDLE);
  assign bus.Busy  = (state_q == RUN);
  assign bus.HiOut = hi_q;
  assign bus.LoOut = lo_q;

endmodule
